// File: rtl/phase_monitor_if.sv
// Wishbone slave bundle for phase_monitor; names carry the slave-side direction prefix.
interface phase_monitor_if;
  logic        i_wb_cyc;
  logic        i_wb_stb;
  logic        i_wb_we;
  logic [31:0] i_wb_addr;
  logic [31:0] i_wb_data;
  logic        o_wb_ack;
  logic [31:0] o_wb_data;

  modport slave  (input  i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
                  output o_wb_ack, o_wb_data);
  modport master (output i_wb_cyc, i_wb_stb, i_wb_we, i_wb_addr, i_wb_data,
                  input  o_wb_ack, o_wb_data);
endinterface

// File: rtl/phase_monitor.sv
// Receive-side monitor for the four-phase sensor clock: decodes frames, measures
// shift/hold/pulse widths, flags protocol errors, exposes results over Wishbone.
module phase_monitor #(
  parameter int unsigned EXPECTED_SHIFTS = 2052,
  parameter logic [31:0] BASE_ADDRESS    = 32'h3000_0020,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic               i_wb_clk,
  input  logic               i_wb_rst_n,
  phase_monitor_if.slave     wb,
  input  logic               i_phi_p,
  input  logic               i_phi_l1,
  input  logic               i_phi_l2,
  input  logic               i_phi_r,
  output logic               o_irq
);

  typedef enum logic [2:0] {S_IDLE, S_WAIT_P, S_SHIFT, S_HOLD, S_PULSE} state_t;

  localparam logic [15:0] EXP_SHIFTS = EXPECTED_SHIFTS[15:0];

  // ---------------- input conditioning ----------------
  logic [SYNC_STAGES-1:0][3:0] r_sync;
  logic [3:0]                  r_v_d;
  logic [3:0]                  w_v;
  logic                        w_p_fall, w_p_rise, w_l1_rise, w_v_legal;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_sync <= '0;
      r_v_d  <= '0;
    end else begin
      r_sync[0] <= {i_phi_p, i_phi_r, i_phi_l2, i_phi_l1};
      for (int i = 1; i < SYNC_STAGES; i++) r_sync[i] <= r_sync[i-1];
      r_v_d <= w_v;
    end
  end

  assign w_v       = r_sync[SYNC_STAGES-1];
  assign w_p_fall  =  r_v_d[3] & ~w_v[3];
  assign w_p_rise  = ~r_v_d[3] &  w_v[3];
  assign w_l1_rise = ~r_v_d[0] &  w_v[0];

  always_comb begin
    w_v_legal = 1'b0;
    case (w_v)
      4'b1110, 4'b0001, 4'b0110, 4'b0010, 4'b0000: w_v_legal = 1'b1;
      default:                                     w_v_legal = 1'b0;
    endcase
  end

  // ---------------- registers ----------------
  logic        r_en;
  logic [3:0]  r_mask;
  logic        r_locked, r_shift_err, r_ill_err, r_ovf;
  logic [15:0] r_last_shift;
  logic [31:0] r_last_hold, r_last_pulse, r_frame_cnt;
  logic [15:0] r_shift_cnt;
  logic [31:0] r_hold_cnt, r_pulse_cnt;
  state_t      r_state, w_state_nxt;

  // ---------------- FSM ----------------
  logic w_shift_start, w_enter_pulse, w_frame_done, w_l1_illegal;

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) r_state <= S_IDLE;
    else             r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_shift_start = 1'b0;
    w_enter_pulse = 1'b0;
    w_frame_done  = 1'b0;
    w_l1_illegal  = 1'b0;
    if (!r_en) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state_nxt = S_WAIT_P;
        S_WAIT_P: if (w_p_fall) begin
                    w_state_nxt   = S_SHIFT;
                    w_shift_start = 1'b1;
                  end
        S_SHIFT:  if (w_v == 4'b0000) w_state_nxt = S_HOLD;
        S_HOLD:   if (w_l1_rise) begin
                    w_state_nxt  = S_WAIT_P;
                    w_l1_illegal = 1'b1;
                  end else if (w_p_rise) begin
                    w_state_nxt   = S_PULSE;
                    w_enter_pulse = 1'b1;
                  end
        // p falling and l1 rising coincide at the start of every shift phase,
        // so the falling edge takes priority over the illegal-l1 check here.
        S_PULSE:  if (w_p_fall) begin
                    w_state_nxt   = S_SHIFT;
                    w_shift_start = 1'b1;
                    w_frame_done  = 1'b1;
                  end else if (w_l1_rise) begin
                    w_state_nxt  = S_WAIT_P;
                    w_l1_illegal = 1'b1;
                  end
        default:  w_state_nxt = S_IDLE;
      endcase
    end
  end

  // ---------------- working counters ----------------
  logic w_shift_inc, w_set_ovf;
  assign w_shift_inc = (r_state == S_SHIFT) && w_l1_rise;
  assign w_set_ovf   = r_en && w_shift_inc && (r_shift_cnt == 16'hFFFF);

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_shift_cnt <= '0;
      r_hold_cnt  <= '0;
      r_pulse_cnt <= '0;
    end else if (!r_en) begin
      r_shift_cnt <= '0;
      r_hold_cnt  <= '0;
      r_pulse_cnt <= '0;
    end else begin
      // The edge that ends p also carries the first l1 rise of the frame.
      if (w_shift_start)
        r_shift_cnt <= {15'd0, w_l1_rise};
      else if (w_shift_inc && r_shift_cnt != 16'hFFFF)
        r_shift_cnt <= r_shift_cnt + 16'd1;

      if (w_shift_start)
        r_hold_cnt <= '0;
      else if (r_state == S_HOLD && r_hold_cnt != 32'hFFFF_FFFF)
        r_hold_cnt <= r_hold_cnt + 32'd1;

      if (w_enter_pulse)
        r_pulse_cnt <= 32'd1;
      else if (r_state == S_PULSE && r_pulse_cnt != 32'hFFFF_FFFF)
        r_pulse_cnt <= r_pulse_cnt + 32'd1;
    end
  end

  // ---------------- Wishbone decode ----------------
  logic [31:0] w_off, w_rdata;
  logic [2:0]  w_idx;
  logic        w_hit, w_acc, w_wr;
  logic [2:0]  w_w1c;
  logic        r_ack;
  logic [31:0] r_rdata;

  assign w_off = wb.i_wb_addr - BASE_ADDRESS;
  assign w_idx = w_off[4:2];
  assign w_hit = wb.i_wb_cyc & wb.i_wb_stb & (w_off < 32'd24);
  assign w_acc = w_hit & ~r_ack;
  assign w_wr  = w_acc & wb.i_wb_we;
  assign w_w1c = (w_wr && w_idx == 3'd1) ? wb.i_wb_data[3:1] : 3'd0;

  logic w_set_shift, w_set_ill, w_frame_clr;
  assign w_set_shift = w_enter_pulse && (r_shift_cnt != EXP_SHIFTS);
  assign w_set_ill   = ((r_state != S_IDLE) && !w_v_legal) || w_l1_illegal;
  assign w_frame_clr = w_wr && (w_idx == 3'd5);

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_en         <= 1'b0;
      r_mask       <= '0;
      r_locked     <= 1'b0;
      r_shift_err  <= 1'b0;
      r_ill_err    <= 1'b0;
      r_ovf        <= 1'b0;
      r_last_shift <= '0;
      r_last_hold  <= '0;
      r_last_pulse <= '0;
      r_frame_cnt  <= '0;
    end else begin
      if (w_wr && w_idx == 3'd0) begin
        r_en   <= wb.i_wb_data[0];
        r_mask <= wb.i_wb_data[7:4];
      end
      // Hardware set wins over a same-cycle write-one-to-clear.
      r_shift_err <= (r_shift_err & ~w_w1c[0]) | w_set_shift;
      r_ill_err   <= (r_ill_err   & ~w_w1c[1]) | w_set_ill;
      r_ovf       <= (r_ovf       & ~w_w1c[2]) | w_set_ovf;

      if (!r_en)             r_locked <= 1'b0;
      else if (w_frame_done) r_locked <= 1'b1;

      if (w_enter_pulse) begin
        r_last_shift <= r_shift_cnt;
        r_last_hold  <= r_hold_cnt;
      end
      if (w_frame_done) r_last_pulse <= r_pulse_cnt;
      r_frame_cnt <= (w_frame_clr ? 32'd0 : r_frame_cnt) + {31'd0, w_frame_done};
    end
  end

  always_comb begin
    w_rdata = '0;
    case (w_idx)
      3'd0:    w_rdata = {24'd0, r_mask, 3'd0, r_en};
      3'd1:    w_rdata = {28'd0, r_ovf, r_ill_err, r_shift_err, r_locked};
      3'd2:    w_rdata = {16'd0, r_last_shift};
      3'd3:    w_rdata = r_last_hold;
      3'd4:    w_rdata = r_last_pulse;
      3'd5:    w_rdata = r_frame_cnt;
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack <= w_acc;
      if (w_acc && !wb.i_wb_we) r_rdata <= w_rdata;
    end
  end

  assign wb.o_wb_ack  = r_ack;
  assign wb.o_wb_data = r_rdata;
  assign o_irq        = |({r_ovf, r_ill_err, r_shift_err} & r_mask[3:1]);

  logic w_unused_ok;
  assign w_unused_ok = &{1'b0, wb.i_wb_data[31:8], r_mask[0]};

endmodule

// File: tb/tb_phase_monitor.sv
// Directed bench for phase_monitor: frame timing, error flags, W1C, disable, reset and bus protocol.
module tb_phase_monitor;
  localparam logic [31:0] BASE = 32'h3000_0020;
  localparam logic [31:0] A_CTRL = BASE + 32'h00, A_STAT = BASE + 32'h04,
                          A_LSH  = BASE + 32'h08, A_LHO  = BASE + 32'h0C,
                          A_LPU  = BASE + 32'h10, A_FRM  = BASE + 32'h14;

  logic clk = 1'b0, rst_n = 1'b0;
  logic phi_p = 1'b0, phi_l1 = 1'b0, phi_l2 = 1'b0, phi_r = 1'b0;
  logic irq;
  int   n_checks = 0, n_fail = 0;

  phase_monitor_if wb();

  phase_monitor dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .wb(wb),
    .i_phi_p(phi_p), .i_phi_l1(phi_l1), .i_phi_l2(phi_l2), .i_phi_r(phi_r),
    .o_irq(irq)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_v(input logic [3:0] v, input int n);
    {phi_p, phi_r, phi_l2, phi_l1} = v;
    repeat (n) tick();
  endtask

  task automatic wb_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rdata, output logic acked);
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = we;
    wb.i_wb_addr = addr; wb.i_wb_data = wdata;
    acked = 1'b0; rdata = '0;
    for (int i = 0; i < 4 && !acked; i++) begin
      tick();
      if (wb.o_wb_ack === 1'b1) begin acked = 1'b1; rdata = wb.o_wb_data; end
    end
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
  endtask

  task automatic rd(input logic [31:0] addr, output logic [31:0] d);
    logic a;
    wb_xfer(1'b0, addr, 32'd0, d, a);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] d);
    logic [31:0] x; logic a;
    wb_xfer(1'b1, addr, d, x, a);
  endtask

  // Assumes V=0001 already driven as the frame's first l1 edge.
  task automatic do_shifts(input int n, input int ill_at);
    drive_v(4'b0110, 1); drive_v(4'b0010, 1);
    for (int i = 1; i < n; i++) begin
      if (i == ill_at) drive_v(4'b1001, 1);
      drive_v(4'b0001, 1); drive_v(4'b0110, 1); drive_v(4'b0010, 1);
    end
  endtask

  task automatic full_frame(input int n, input int h, input int pw, input int ill_at);
    do_shifts(n, ill_at);
    drive_v(4'b0000, h);
    drive_v(4'b1110, pw);
    drive_v(4'b0001, 4);
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic [31:0] addrs [6];
    addrs = '{A_CTRL, A_STAT, A_LSH, A_LHO, A_LPU, A_FRM};
    n_checks++; if (wb.o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL reset_ack: got %b expected 0", wb.o_wb_ack); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL reset_irq: got %b expected 0", irq); end
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL reset_reg%0d: got %h expected 0", i, d); end
    end
  endtask

  task automatic test_nominal();
    logic [31:0] d;
    wr(A_CTRL, 32'h1);
    drive_v(4'b1110, 5);
    drive_v(4'b0001, 1);
    full_frame(2052, 500, 40, -1);
    rd(A_LSH, d);
    n_checks++; if (d !== 32'd2052) begin n_fail++; $display("FAIL nom_last_shift: got %0d expected 2052", d); end
    rd(A_LHO, d);
    n_checks++; if (d < 32'd499 || d > 32'd501) begin n_fail++; $display("FAIL nom_last_hold: got %0d expected 500+-1", d); end
    rd(A_LPU, d);
    n_checks++; if (d !== 32'd40) begin n_fail++; $display("FAIL nom_last_pulse: got %0d expected 40", d); end
    rd(A_FRM, d);
    n_checks++; if (d !== 32'd1) begin n_fail++; $display("FAIL nom_frames: got %0d expected 1", d); end
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL nom_status: got %h expected 1", d); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL nom_irq: got %b expected 0", irq); end
  endtask

  task automatic test_short_frame();
    logic [31:0] d;
    wr(A_CTRL, 32'h21);
    full_frame(2051, 20, 10, -1);
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL short_status: got %h expected 3", d); end
    n_checks++; if (irq !== 1'b1) begin n_fail++; $display("FAIL short_irq: got %b expected 1", irq); end
    rd(A_LSH, d);
    n_checks++; if (d !== 32'd2051) begin n_fail++; $display("FAIL short_last_shift: got %0d expected 2051", d); end
    wr(A_STAT, 32'h2);
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL short_w1c: got %h expected 1", d); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL short_irq_clr: got %b expected 0", irq); end
  endtask

  task automatic test_illegal();
    logic [31:0] d;
    full_frame(2052, 20, 10, 100);
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h5) begin n_fail++; $display("FAIL ill_status: got %h expected 5", d); end
    rd(A_LSH, d);
    n_checks++; if (d !== 32'd2052) begin n_fail++; $display("FAIL ill_last_shift: got %0d expected 2052", d); end
    rd(A_FRM, d);
    n_checks++; if (d !== 32'd3) begin n_fail++; $display("FAIL ill_frames: got %0d expected 3", d); end
    n_checks++; if (irq !== 1'b0) begin n_fail++; $display("FAIL ill_irq_masked: got %b expected 0", irq); end
    wr(A_STAT, 32'h4);
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL ill_w1c: got %h expected 1", d); end
  endtask

  task automatic test_w1c_collision();
    logic [31:0] d;
    do_shifts(2051, -1);
    drive_v(4'b0000, 20);
    {phi_p, phi_r, phi_l2, phi_l1} = 4'b1110;
    tick(); tick();
    // Bus write sampled on the same edge the synchronized p rise moves HOLD->PULSE.
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b1;
    wb.i_wb_addr = A_STAT; wb.i_wb_data = 32'h2;
    tick();
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
    drive_v(4'b1110, 10);
    drive_v(4'b0001, 4);
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL collision_status: got %h expected 3", d); end
    rd(A_FRM, d);
    n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL collision_frames: got %0d expected 4", d); end
    wr(A_STAT, 32'h2);
  endtask

  task automatic test_disable();
    logic [31:0] d;
    do_shifts(2052, -1);
    drive_v(4'b0000, 30);
    wr(A_CTRL, 32'h20);
    drive_v(4'b0000, 3);
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dis_status: got %h expected 0", d); end
    rd(A_LSH, d);
    n_checks++; if (d !== 32'd2051) begin n_fail++; $display("FAIL dis_last_shift: got %0d expected 2051", d); end
    rd(A_LPU, d);
    n_checks++; if (d !== 32'd13) begin n_fail++; $display("FAIL dis_last_pulse: got %0d expected 13", d); end
    wr(A_CTRL, 32'h21);
    drive_v(4'b1110, 10);
    drive_v(4'b0001, 4);
    rd(A_FRM, d);
    n_checks++; if (d !== 32'd4) begin n_fail++; $display("FAIL dis_frames_hold: got %0d expected 4", d); end
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL dis_unlocked: got %h expected 0", d); end
    full_frame(2052, 25, 17, -1);
    rd(A_FRM, d);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL reen_frames: got %0d expected 5", d); end
    rd(A_STAT, d);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL reen_status: got %h expected 1", d); end
    rd(A_LPU, d);
    n_checks++; if (d !== 32'd17) begin n_fail++; $display("FAIL reen_last_pulse: got %0d expected 17", d); end
  endtask

  task automatic test_bus_protocol();
    logic [31:0] d;
    int acks;
    logic [2:0] pat;
    rd(A_FRM, d);
    n_checks++; if (d !== 32'd5) begin n_fail++; $display("FAIL bus_prime: got %0d expected 5", d); end
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_addr = BASE + 32'h18;
    acks = 0;
    repeat (4) begin tick(); if (wb.o_wb_ack === 1'b1) acks++; end
    n_checks++; if (acks !== 0) begin n_fail++; $display("FAIL bus_oob_ack: got %0d acks expected 0", acks); end
    n_checks++; if (wb.o_wb_data !== 32'd5) begin n_fail++; $display("FAIL bus_oob_data: got %h expected 5", wb.o_wb_data); end
    wb.i_wb_addr = A_LSH;
    for (int i = 0; i < 3; i++) begin
      tick();
      pat[2-i] = wb.o_wb_ack;
      if (i != 1) begin
        n_checks++; if (wb.o_wb_data !== 32'd2052) begin n_fail++; $display("FAIL bus_burst_data%0d: got %0d expected 2052", i, wb.o_wb_data); end
      end
    end
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
    n_checks++; if (pat !== 3'b101) begin n_fail++; $display("FAIL bus_ack_pattern: got %b expected 101", pat); end
    wr(A_LSH, 32'hDEAD);
    rd(A_LSH, d);
    n_checks++; if (d !== 32'd2052) begin n_fail++; $display("FAIL bus_ro_write: got %h expected 804", d); end
    rd(A_CTRL, d);
    n_checks++; if (d !== 32'h21) begin n_fail++; $display("FAIL bus_ctrl_rb: got %h expected 21", d); end
    wr(A_FRM, 32'h1234);
    rd(A_FRM, d);
    n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL bus_frame_clr: got %0d expected 0", d); end
  endtask

  task automatic test_reset_mid_pulse();
    logic [31:0] d;
    logic [31:0] addrs [6];
    addrs = '{A_CTRL, A_STAT, A_LSH, A_LHO, A_LPU, A_FRM};
    do_shifts(2052, -1);
    drive_v(4'b0000, 10);
    drive_v(4'b1110, 8);
    wb.i_wb_cyc = 1'b1; wb.i_wb_stb = 1'b1; wb.i_wb_we = 1'b0; wb.i_wb_addr = A_LSH;
    tick();
    n_checks++; if (wb.o_wb_ack !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ack: got %b expected 1", wb.o_wb_ack); end
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (wb.o_wb_ack !== 1'b0) begin n_fail++; $display("FAIL rst_async_ack: got %b expected 0", wb.o_wb_ack); end
    n_checks++; if (wb.o_wb_data !== 32'd0) begin n_fail++; $display("FAIL rst_async_data: got %h expected 0", wb.o_wb_data); end
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      rd(addrs[i], d);
      n_checks++; if (d !== 32'd0) begin n_fail++; $display("FAIL rst_reg%0d: got %h expected 0", i, d); end
    end
  endtask

  initial begin
    wb.i_wb_cyc = 1'b0; wb.i_wb_stb = 1'b0; wb.i_wb_we = 1'b0;
    wb.i_wb_addr = '0; wb.i_wb_data = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_nominal();
    test_short_frame();
    test_illegal();
    test_w1c_collision();
    test_disable();
    test_bus_protocol();
    test_reset_mid_pulse();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
